calc_sequencer: RTL and testbench
=================================

CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clk and reset.
REQ-002 The block SHALL have these ports, one per line as name, direction, width, meaning:
- clk  in  1  system clock
- reset  in  1  sync active-high reset
- key_valid  in  1  one-cycle strobe, key_code valid
- key_code  in  4  0-9 digit; 10 ADD; 11 SUB; 12 MUL; 13 DIV; 14 ENTER; 15 CLEAR
- math_done  in  1  result ready from math unit
- num_state  out  3  000 OP1, 001 OPR, 010 OP2, 100 CALC, 011 RESULT
- tens_mem_1, ones_mem_1  out  5 each  operand 1 digits
- tens_mem_2, ones_mem_2  out  5 each  operand 2 digits
- arithmetic  out  5  one-hot op: 00001 add, 00010 sub, 00100 mul, 01000 div, 00000 none
- math_start  out  1  one-cycle request to math unit
- error  out  1  sticky math-timeout flag
REQ-003 The block SHALL have one parameter, TIMEOUT, default 255: the maximum number of cycles spent waiting for math_done.

Function
REQ-004 Every register SHALL update only on the rising edge of clk; the block SHALL act on a key only in a cycle where key_valid=1.
REQ-005 Digit entry in OP1 or OP2 SHALL work as follows:
- 1st digit: written to ones, tens stays 0.
- 2nd digit: ones moves to tens, new digit written to ones.
- Further digits: ignored.
REQ-006 In OP1, a digit key SHALL update the operand-1 pair.
REQ-007 In OP1, an op key (10-13) SHALL load arithmetic and move to OPR; ENTER SHALL be ignored.
REQ-008 In OPR, a further op key SHALL overwrite arithmetic.
REQ-009 In OPR, a digit SHALL go to OP2 and be captured as the first operand-2 digit in the same cycle.
REQ-010 In OP2, a digit SHALL update the operand-2 pair.
REQ-011 In OP2, ENTER SHALL move to CALC; op keys SHALL be ignored.
REQ-012 Entering CALC, math_start SHALL be high for exactly the one cycle after the ENTER cycle.
REQ-013 In CALC, a wait counter SHALL start at 0 and increment every cycle.
REQ-014 In CALC, math_done=1 SHALL move to RESULT on the next edge.
REQ-015 In CALC, if the counter reaches TIMEOUT with math_done=0, the block SHALL set error=1 and move to RESULT.
REQ-016 If math_done and the timeout occur in the same cycle, math_done SHALL win and error SHALL stay 0.
REQ-017 In CALC, all keys except CLEAR SHALL be ignored.
REQ-018 In RESULT, a digit SHALL clear both operands, arithmetic and error, write the digit as operand-1 ones, and go to OP1.
REQ-019 In RESULT, all other non-CLEAR keys SHALL be ignored.
REQ-020 CLEAR in any state SHALL, on the next edge, return to OP1 and zero all digits, arithmetic, the counter, math_start and error. CLEAR during CALC SHALL abandon the pending result.
REQ-021 math_done SHALL be ignored outside CALC.
REQ-022 All outputs SHALL be registered, with no combinational path from any input to any output.
REQ-023 Digit registers SHALL only ever hold values 0-9; bits [4] of all digit outputs SHALL always be 0.

Reset
REQ-024 Reset SHALL have the same effect as CLEAR and SHALL override key_valid and math_done in the same cycle.
REQ-025 After reset, the outputs SHALL be:
- num_state 000
- all digit outputs 0
- arithmetic 00000
- math_start 0
- error 0

Structure
REQ-026 The state enum, num_state encodings, key_code constants and arithmetic one-hot constants SHALL live in the shared package calc_pkg, which the display mux and math unit also import.
REQ-027 The digit shift-entry logic SHALL be a single sub-module, digit_entry, instantiated once per operand, with ports clk, reset, clr, load, digit, tens and ones.
REQ-028 The FSM and the timeout counter SHALL stay in calc_sequencer.

Verification
REQ-029 Key sequence 4,2,ADD,7,ENTER with math_done 3 cycles after math_start SHALL give:
- operand 1 = 4/2, operand 2 = 0/7
- arithmetic 00001
- math_start exactly 1 cycle
- num_state 011, error 0
REQ-030 Keys 1,2,3 in OP1 SHALL leave tens_mem_1=1, ones_mem_1=2.
REQ-031 With math_done held 0 after ENTER, the block SHALL reach RESULT with error=1 exactly TIMEOUT cycles after entering CALC.
REQ-032 CLEAR during CALC, then math_done pulsed, SHALL give num_state 000 with all registers zero and no RESULT entry.
REQ-033 Keys SUB then MUL in OPR SHALL give arithmetic 00100; ENTER in OP1 SHALL cause no state change.
REQ-034 Reset asserted in OP2 together with key_valid digit 5 SHALL give the reset state and leave ones_mem_2=0.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator datapath: the sequencer state encoding (also the
// num_state output code), key codes, one-hot arithmetic codes and small key-decode helpers.
// The display mux and the math unit import this package as well.
package calc_pkg;

  // Encodings are visible on num_state, so they are fixed explicitly.
  typedef enum logic [2:0] {
    StOp1    = 3'b000,
    StOpr    = 3'b001,
    StOp2    = 3'b010,
    StResult = 3'b011,
    StCalc   = 3'b100
  } num_state_e;

  localparam logic [3:0] KeyAdd   = 4'd10;
  localparam logic [3:0] KeySub   = 4'd11;
  localparam logic [3:0] KeyMul   = 4'd12;
  localparam logic [3:0] KeyDiv   = 4'd13;
  localparam logic [3:0] KeyEnter = 4'd14;
  localparam logic [3:0] KeyClear = 4'd15;

  localparam logic [4:0] ArithNone = 5'b00000;
  localparam logic [4:0] ArithAdd  = 5'b00001;
  localparam logic [4:0] ArithSub  = 5'b00010;
  localparam logic [4:0] ArithMul  = 5'b00100;
  localparam logic [4:0] ArithDiv  = 5'b01000;

  function automatic logic is_digit(input logic [3:0] key);
    return key <= 4'd9;
  endfunction

  function automatic logic is_op(input logic [3:0] key);
    return (key >= KeyAdd) && (key <= KeyDiv);
  endfunction

  function automatic logic [4:0] op_onehot(input logic [3:0] key);
    logic [4:0] arith;
    case (key)
      KeyAdd:  arith = ArithAdd;
      KeySub:  arith = ArithSub;
      KeyMul:  arith = ArithMul;
      KeyDiv:  arith = ArithDiv;
      default: arith = ArithNone;
    endcase
    return arith;
  endfunction

endpackage

// File: rtl/digit_entry.sv
// Two-digit shift-entry register for one operand.
// Ports:
//   clk    system clock
//   reset  synchronous active-high reset
//   clr    zero both digits and restart entry (may coincide with load)
//   load   digit strobe; first digit lands in ones, second shifts ones to tens, rest ignored
//   digit  key code carrying the digit (non-digit codes are never stored)
//   tens   tens digit, bit 4 always 0
//   ones   ones digit, bit 4 always 0
module digit_entry
  import calc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       load,
  input  logic [3:0] digit,
  output logic [4:0] tens,
  output logic [4:0] ones
);

  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;
  logic [1:0] cnt_q, cnt_d;  // digits accepted so far, saturates at 2

  always_comb begin
    tens_d = tens_q;
    ones_d = ones_q;
    cnt_d  = cnt_q;
    if (clr) begin
      tens_d = '0;
      ones_d = '0;
      cnt_d  = '0;
    end
    // Evaluated after clr so a clear-and-load cycle captures the digit as the first one.
    if (load && is_digit(digit)) begin
      if (cnt_d == 2'd0) begin
        ones_d = digit;
        cnt_d  = 2'd1;
      end else if (cnt_d == 2'd1) begin
        tens_d = ones_d;
        ones_d = digit;
        cnt_d  = 2'd2;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tens_q <= '0;
      ones_q <= '0;
      cnt_q  <= '0;
    end else begin
      tens_q <= tens_d;
      ones_q <= ones_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage is 4 bits wide, so the top output bit is structurally zero.
  assign tens = {1'b0, tens_q};
  assign ones = {1'b0, ones_q};

endmodule

// File: rtl/calc_sequencer.sv
// Calculator key sequencer: collects two 2-digit operands and an operator, launches the
// math unit, waits for its completion with a timeout, and holds the result state.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   key_valid, key_code        one-cycle key strobe and code (0-9, ops 10-13, ENTER, CLEAR)
//   math_done                  completion from the math unit (only heeded in CALC)
//   num_state                  sequencer state code
//   tens_mem_1/ones_mem_1      operand 1 digits
//   tens_mem_2/ones_mem_2      operand 2 digits
//   arithmetic                 one-hot operator
//   math_start                 one-cycle launch pulse on entering CALC
//   error                      sticky math-timeout flag
// TIMEOUT must be at least 1.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       math_done,
  output logic [2:0] num_state,
  output logic [4:0] tens_mem_1,
  output logic [4:0] ones_mem_1,
  output logic [4:0] tens_mem_2,
  output logic [4:0] ones_mem_2,
  output logic [4:0] arithmetic,
  output logic       math_start,
  output logic       error
);

  // The counter only ever holds 0..TIMEOUT-1 before CALC is left.
  localparam int unsigned CntW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT - 1);

  num_state_e     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [4:0]     arith_q, arith_d;
  logic           start_q, start_d;
  logic           error_q, error_d;

  logic key_clear, key_digit, key_op, key_enter;
  logic load_1, load_2, clr_ops;

  assign key_clear = key_valid && (key_code == KeyClear);
  assign key_digit = key_valid && is_digit(key_code);
  assign key_op    = key_valid && is_op(key_code);
  assign key_enter = key_valid && (key_code == KeyEnter);

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    arith_d = arith_q;
    start_d = 1'b0;
    error_d = error_q;
    load_1  = 1'b0;
    load_2  = 1'b0;
    clr_ops = 1'b0;

    if (key_clear) begin
      state_d = StOp1;
      arith_d = ArithNone;
      error_d = 1'b0;
      clr_ops = 1'b1;
    end else begin
      unique case (state_q)
        StOp1: begin
          if (key_digit) begin
            load_1 = 1'b1;
          end else if (key_op) begin
            arith_d = op_onehot(key_code);
            state_d = StOpr;
          end
        end
        StOpr: begin
          if (key_op) begin
            arith_d = op_onehot(key_code);
          end else if (key_digit) begin
            load_2  = 1'b1;
            state_d = StOp2;
          end
        end
        StOp2: begin
          if (key_digit) begin
            load_2 = 1'b1;
          end else if (key_enter) begin
            start_d = 1'b1;
            state_d = StCalc;
          end
        end
        StCalc: begin
          // math_done takes priority over a timeout landing in the same cycle.
          if (math_done) begin
            state_d = StResult;
          end else if (cnt_q == TimeoutLast) begin
            error_d = 1'b1;
            state_d = StResult;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StResult: begin
          if (key_digit) begin
            clr_ops = 1'b1;
            load_1  = 1'b1;
            arith_d = ArithNone;
            error_d = 1'b0;
            state_d = StOp1;
          end
        end
        default: state_d = StOp1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StOp1;
      cnt_q   <= '0;
      arith_q <= ArithNone;
      start_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      arith_q <= arith_d;
      start_q <= start_d;
      error_q <= error_d;
    end
  end

  digit_entry u_operand_1 (
    .clk   (clk),
    .reset (reset),
    .clr   (clr_ops),
    .load  (load_1),
    .digit (key_code),
    .tens  (tens_mem_1),
    .ones  (ones_mem_1)
  );

  digit_entry u_operand_2 (
    .clk   (clk),
    .reset (reset),
    .clr   (clr_ops),
    .load  (load_2),
    .digit (key_code),
    .tens  (tens_mem_2),
    .ones  (ones_mem_2)
  );

  assign num_state  = state_q;
  assign arithmetic = arith_q;
  assign math_start = start_q;
  assign error      = error_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Scoreboard bench for calc_sequencer: the driver pushes expected output snapshots, expected
// RESULT entries and expected math_start cycles into queues; a negedge monitor pops and compares.
module tb_calc_sequencer;
  import calc_pkg::*;

  localparam int unsigned TO = 255;

  logic       clk = 1'b0;
  logic       reset;
  logic       key_valid;
  logic [3:0] key_code;
  logic       math_done;
  logic [2:0] num_state;
  logic [4:0] tens_mem_1, ones_mem_1, tens_mem_2, ones_mem_2;
  logic [4:0] arithmetic;
  logic       math_start;
  logic       error;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct packed {
    int         cyc;
    logic [2:0] st;
    logic [4:0] t1;
    logic [4:0] o1;
    logic [4:0] t2;
    logic [4:0] o2;
    logic [4:0] ar;
    logic       err;
  } exp_t;

  exp_t  snap_q[$];
  string snap_name_q[$];
  exp_t  res_q[$];
  string res_name_q[$];
  int    start_q[$];

  calc_sequencer #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .math_done  (math_done),
    .num_state  (num_state),
    .tens_mem_1 (tens_mem_1),
    .ones_mem_1 (ones_mem_1),
    .tens_mem_2 (tens_mem_2),
    .ones_mem_2 (ones_mem_2),
    .arithmetic (arithmetic),
    .math_start (math_start),
    .error      (error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_exp(input exp_t e, input string name);
    checks++;
    if (cyc != e.cyc || num_state !== e.st || tens_mem_1 !== e.t1 || ones_mem_1 !== e.o1 ||
        tens_mem_2 !== e.t2 || ones_mem_2 !== e.o2 || arithmetic !== e.ar || error !== e.err) begin
      errors++;
      $display("FAIL %s: got cyc=%0d st=%b op1=%0d/%0d op2=%0d/%0d ar=%b err=%b, exp cyc=%0d st=%b op1=%0d/%0d op2=%0d/%0d ar=%b err=%b",
               name, cyc, num_state, tens_mem_1, ones_mem_1, tens_mem_2, ones_mem_2, arithmetic,
               error, e.cyc, e.st, e.t1, e.o1, e.t2, e.o2, e.ar, e.err);
    end
  endtask

  // Monitor
  logic [2:0] prev_st = 3'b000;
  always @(negedge clk) begin
    while (snap_q.size() > 0 && snap_q[0].cyc <= cyc) begin
      check_exp(snap_q.pop_front(), snap_name_q.pop_front());
    end
    if (num_state === 3'b011 && prev_st !== 3'b011) begin
      if (res_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: RESULT entered at cyc=%0d, none expected", cyc);
      end else begin
        check_exp(res_q.pop_front(), res_name_q.pop_front());
      end
    end
    if (math_start === 1'b1) begin
      checks++;
      if (start_q.size() == 0 || start_q[0] != cyc) begin
        errors++;
        $display("FAIL math_start_pulse: high at cyc=%0d, expected at %0d", cyc,
                 (start_q.size() > 0) ? start_q[0] : -1);
      end
      if (start_q.size() > 0) void'(start_q.pop_front());
    end
    prev_st <= num_state;
  end

  // Driver helpers: one call = one clock of input, applied at a negedge.
  task automatic drive(input logic rst, input logic v, input logic [3:0] code, input logic md);
    @(negedge clk);
    reset     = rst;
    key_valid = v;
    key_code  = code;
    math_done = md;
  endtask

  task automatic key(input logic [3:0] code);
    drive(1'b0, 1'b1, code, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 4'd0, 1'b0);
  endtask

  function automatic exp_t mk(input logic [2:0] st, input logic [4:0] t1, input logic [4:0] o1,
                              input logic [4:0] t2, input logic [4:0] o2, input logic [4:0] ar,
                              input logic err);
    exp_t e;
    e.cyc = cyc + 1;
    e.st  = st;
    e.t1  = t1;
    e.o1  = o1;
    e.t2  = t2;
    e.o2  = o2;
    e.ar  = ar;
    e.err = err;
    return e;
  endfunction

  // Expectations refer to the outputs right after the edge that consumes the last drive.
  task automatic snap(input string name, input logic [2:0] st, input logic [4:0] t1,
                      input logic [4:0] o1, input logic [4:0] t2, input logic [4:0] o2,
                      input logic [4:0] ar, input logic err);
    snap_q.push_back(mk(st, t1, o1, t2, o2, ar, err));
    snap_name_q.push_back(name);
  endtask

  task automatic expect_result(input string name, input logic [4:0] t1, input logic [4:0] o1,
                               input logic [4:0] t2, input logic [4:0] o2, input logic [4:0] ar,
                               input logic err);
    res_q.push_back(mk(3'b011, t1, o1, t2, o2, ar, err));
    res_name_q.push_back(name);
  endtask

  task automatic expect_start();
    start_q.push_back(cyc + 1);
  endtask

  task automatic check_empty(input string name, input int n);
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL %s: %0d expected events never seen, required 0", name, n);
    end
  endtask

  initial begin
    reset     = 1'b1;
    key_valid = 1'b0;
    key_code  = 4'd0;
    math_done = 1'b0;

    // Reset, including reset overriding a key and math_done in the same cycle
    drive(1'b1, 1'b0, 4'd0, 1'b0);
    snap("reset_state", 3'b000, 0, 0, 0, 0, 5'b00000, 0);
    drive(1'b1, 1'b1, KeyAdd, 1'b1);
    snap("reset_overrides_key", 3'b000, 0, 0, 0, 0, 5'b00000, 0);

    // 4,2,ADD,7,ENTER with math_done 3 cycles after math_start
    key(4'd4);
    snap("op1_first_digit", 3'b000, 0, 4, 0, 0, 5'b00000, 0);
    drive(1'b0, 1'b0, 4'd7, 1'b0);
    snap("no_key_valid_ignored", 3'b000, 0, 4, 0, 0, 5'b00000, 0);
    key(4'd2);
    snap("op1_two_digits", 3'b000, 4, 2, 0, 0, 5'b00000, 0);
    key(KeyAdd);
    snap("opr_add", 3'b001, 4, 2, 0, 0, 5'b00001, 0);
    key(4'd7);
    snap("opr_digit_to_op2", 3'b010, 4, 2, 0, 7, 5'b00001, 0);
    key(KeyEnter);
    expect_start();
    snap("enter_calc", 3'b100, 4, 2, 0, 7, 5'b00001, 0);
    idle(3);
    drive(1'b0, 1'b0, 4'd0, 1'b1);
    expect_result("math_done_result", 4, 2, 0, 7, 5'b00001, 0);
    idle(1);
    drive(1'b0, 1'b0, 4'd0, 1'b1);
    snap("math_done_ignored_in_result", 3'b011, 4, 2, 0, 7, 5'b00001, 0);
    key(KeySub);
    snap("op_ignored_in_result", 3'b011, 4, 2, 0, 7, 5'b00001, 0);
    key(4'd8);
    snap("result_digit_restart", 3'b000, 0, 8, 0, 0, 5'b00000, 0);

    // Third digit ignored, ENTER ignored in OP1, operator overwrite, timeout
    key(KeyClear);
    snap("clear_in_op1", 3'b000, 0, 0, 0, 0, 5'b00000, 0);
    key(4'd1);
    key(4'd2);
    key(4'd3);
    snap("third_digit_ignored", 3'b000, 1, 2, 0, 0, 5'b00000, 0);
    key(KeyEnter);
    snap("enter_ignored_in_op1", 3'b000, 1, 2, 0, 0, 5'b00000, 0);
    key(KeySub);
    snap("opr_sub", 3'b001, 1, 2, 0, 0, 5'b00010, 0);
    key(KeyMul);
    snap("opr_mul_overwrites", 3'b001, 1, 2, 0, 0, 5'b00100, 0);
    key(4'd5);
    key(KeyAdd);
    snap("op_ignored_in_op2", 3'b010, 1, 2, 0, 5, 5'b00100, 0);
    key(4'd6);
    snap("op2_two_digits", 3'b010, 1, 2, 5, 6, 5'b00100, 0);
    key(KeyEnter);
    expect_start();
    idle(TO - 1);
    snap("calc_before_timeout", 3'b100, 1, 2, 5, 6, 5'b00100, 0);
    idle(1);
    expect_result("timeout_error", 1, 2, 5, 6, 5'b00100, 1);
    idle(1);
    key(KeyMul);
    snap("error_sticky", 3'b011, 1, 2, 5, 6, 5'b00100, 1);
    key(4'd3);
    snap("digit_clears_error", 3'b000, 0, 3, 0, 0, 5'b00000, 0);

    // math_done on the very cycle the timeout would fire
    key(KeyAdd);
    key(4'd9);
    key(KeyEnter);
    expect_start();
    idle(TO - 1);
    drive(1'b0, 1'b0, 4'd0, 1'b1);
    expect_result("done_wins_tie", 0, 3, 0, 9, 5'b00001, 0);

    // CLEAR during CALC abandons the result
    idle(1);
    key(4'd1);
    snap("restart_op1", 3'b000, 0, 1, 0, 0, 5'b00000, 0);
    key(KeyAdd);
    key(4'd2);
    key(KeyEnter);
    expect_start();
    idle(1);
    key(KeyClear);
    snap("clear_in_calc", 3'b000, 0, 0, 0, 0, 5'b00000, 0);
    drive(1'b0, 1'b0, 4'd0, 1'b1);
    snap("math_done_after_clear", 3'b000, 0, 0, 0, 0, 5'b00000, 0);
    idle(3);

    // Reset in OP2 together with a digit key
    key(4'd4);
    key(KeyDiv);
    snap("opr_div", 3'b001, 0, 4, 0, 0, 5'b01000, 0);
    key(4'd1);
    snap("op2_entry", 3'b010, 0, 4, 0, 1, 5'b01000, 0);
    drive(1'b1, 1'b1, 4'd5, 1'b0);
    snap("reset_in_op2", 3'b000, 0, 0, 0, 0, 5'b00000, 0);
    idle(4);

    check_empty("pending_snapshots", snap_q.size());
    check_empty("pending_results", res_q.size());
    check_empty("pending_math_start", start_q.size());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
